// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the CPU/DMA SRAM arbiter.
// Imported by the arbiter and by anything that names its states or ports.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ARB,
    LOCK_P0,
    LOCK_P1
  } state_t;

  localparam int P_CPU = 0;
  localparam int P_DMA = 1;

  localparam int ADDR_W_DEF    = 14;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 16;

endpackage

// File: rtl/sram_arbiter.sv
// Round-robin CPU/DMA arbiter for the single-port SRAM with bounded
// burst locking and a registered one-cycle read-return pipe.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic              LOCK0,
  input  logic              LOCK1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              GNT0,
  output logic              GNT1,
  output logic [DATA_W-1:0] RDATA0,
  output logic [DATA_W-1:0] RDATA1,
  output logic              RVALID0,
  output logic              RVALID1,
  output logic              SRAMCS,
  output logic              SRAMWEN,
  output logic [ADDR_W-1:0] SRAMADDR,
  output logic [DATA_W-1:0] SRAMWDATA,
  input  logic [DATA_W-1:0] SRAMRDATA
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  state_t        state, state_n;
  logic          last, last_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [1:0]    rd_pend;

  logic          win0, win1;
  logic          own;
  logic          lock_own;
  logic          lk_win;
  logic          req_other;
  logic [BW-1:0] cnt_inc;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ARB;
      last    <= 1'b1;
      bcnt    <= '0;
      rd_pend <= 2'b00;
    end else begin
      state   <= state_n;
      last    <= last_n;
      bcnt    <= bcnt_n;
      rd_pend <= {GNT1 & ~WE1, GNT0 & ~WE0};
    end
  end

  always_comb begin
    win0      = 1'b0;
    win1      = 1'b0;
    state_n   = state;
    last_n    = last;
    bcnt_n    = bcnt;
    own       = (state == LOCK_P1);
    lk_win    = 1'b0;
    req_other = 1'b0;
    cnt_inc   = (bcnt >= BMAX) ? BMAX : bcnt + 1'b1;
    lock_own  = (state == LOCK_P0 && REQ0) ||
                (state == LOCK_P1 && REQ1);
    if (lock_own) begin
      win0      = ~own;
      win1      = own;
      lk_win    = own ? LOCK1 : LOCK0;
      req_other = own ? REQ0 : REQ1;
      bcnt_n    = cnt_inc;
      last_n    = own;
      if (!lk_win || (cnt_inc == BMAX && req_other)) begin
        state_n = ARB;
        bcnt_n  = '0;
      end
    end else begin
      // A lock whose owner dropped REQ falls through to plain arbitration
      win0      = REQ0 & (~REQ1 | last);
      win1      = REQ1 & (~REQ0 | ~last);
      lk_win    = win1 ? LOCK1 : LOCK0;
      req_other = win1 ? REQ0 : REQ1;
      state_n   = ARB;
      bcnt_n    = '0;
      if (win0 || win1) begin
        last_n = win1;
        if (lk_win && !(MAX_BURST == 1 && req_other)) begin
          state_n = win1 ? LOCK_P1 : LOCK_P0;
          bcnt_n  = BW'(1);
        end
      end
    end
  end

  assign GNT0      = win0 & HRESETn;
  assign GNT1      = win1 & HRESETn;
  assign SRAMCS    = GNT0 | GNT1;
  assign SRAMWEN   = GNT1 ? WE1 : (GNT0 & WE0);
  assign SRAMADDR  = win1 ? ADDR1 : ADDR0;
  assign SRAMWDATA = win1 ? WDATA1 : WDATA0;

  assign RVALID0 = rd_pend[P_CPU];
  assign RVALID1 = rd_pend[P_DMA];
  assign RDATA0  = rd_pend[P_CPU] ? SRAMRDATA : '0;
  assign RDATA1  = rd_pend[P_DMA] ? SRAMRDATA : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM model.
// A second instance uses MAX_BURST=4 for the forced-release case.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic req0, req1, we0, we1, lk0, lk1;
  logic [13:0] addr0, addr1;
  logic [7:0] wd0, wd1;
  logic gnt0, gnt1, rv0, rv1, cs, wen;
  logic [7:0] rd0, rd1, swd, srd;
  logic [13:0] saddr;

  logic req0b, req1b, lk0b, lk1b;
  logic gnt0b, gnt1b, rv0b, rv1b, csb, wenb;
  logic [7:0] rd0b, rd1b, swdb;
  logic [13:0] saddrb;
  logic [13:0] zaddr;
  logic [7:0] zdata;

  logic [7:0] mem [0:16383];

  int checks = 0;
  int errors = 0;

  sram_arbiter dut (
    .HCLK(clk), .HRESETn(rst_n),
    .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
    .LOCK0(lk0), .LOCK1(lk1),
    .ADDR0(addr0), .ADDR1(addr1),
    .WDATA0(wd0), .WDATA1(wd1),
    .GNT0(gnt0), .GNT1(gnt1),
    .RDATA0(rd0), .RDATA1(rd1),
    .RVALID0(rv0), .RVALID1(rv1),
    .SRAMCS(cs), .SRAMWEN(wen),
    .SRAMADDR(saddr), .SRAMWDATA(swd),
    .SRAMRDATA(srd)
  );

  sram_arbiter #(.MAX_BURST(4)) dut4 (
    .HCLK(clk), .HRESETn(rst_n),
    .REQ0(req0b), .REQ1(req1b), .WE0(1'b0), .WE1(1'b0),
    .LOCK0(lk0b), .LOCK1(lk1b),
    .ADDR0(zaddr), .ADDR1(zaddr),
    .WDATA0(zdata), .WDATA1(zdata),
    .GNT0(gnt0b), .GNT1(gnt1b),
    .RDATA0(rd0b), .RDATA1(rd1b),
    .RVALID0(rv0b), .RVALID1(rv1b),
    .SRAMCS(csb), .SRAMWEN(wenb),
    .SRAMADDR(saddrb), .SRAMWDATA(swdb),
    .SRAMRDATA(zdata)
  );

  always @(posedge clk) begin
    if (cs) begin
      if (wen) mem[saddr] <= swd;
      else srd <= mem[saddr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lk0 = 0; lk1 = 0;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
    req0b = 0; req1b = 0; lk0b = 0; lk1b = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    req0 = 1; req1 = 1; we0 = 1; req0b = 1; req1b = 1;
    #2;
    checks++;
    if ({gnt0, gnt1, cs, wen, rv0, rv1} !== 6'b0 ||
        rd0 !== 8'h00 || rd1 !== 8'h00 || {gnt0b, gnt1b} !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b cs=%b wen=%b rv=%b%b rd0=%h rd1=%h want all 0",
               gnt0, gnt1, cs, wen, rv0, rv1, rd0, rd1);
    end
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1; we0 = 1; addr0 = 14'h0010; wd0 = 8'hA5;
    #2;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || wen !== 1'b1 ||
        saddr !== 14'h0010 || swd !== 8'hA5) begin
      errors++;
      $display("FAIL single_write: gnt0=%b wen=%b addr=%h wd=%h want 1 1 0010 a5",
               gnt0, wen, saddr, swd);
    end
    tick();
    we0 = 0;
    #2;
    checks++;
    if (gnt0 !== 1'b1 || wen !== 1'b0 || rv0 !== 1'b0 || rd0 !== 8'h00) begin
      errors++;
      $display("FAIL single_read_grant: gnt0=%b wen=%b rv0=%b rd0=%h want 1 0 0 00",
               gnt0, wen, rv0, rd0);
    end
    tick();
    req0 = 0;
    #2;
    checks++;
    if (rv0 !== 1'b1 || rd0 !== 8'hA5 || rv1 !== 1'b0) begin
      errors++;
      $display("FAIL single_read_data: rv0=%b rd0=%h rv1=%b want 1 a5 0",
               rv0, rd0, rv1);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    req0 = 1; req1 = 1; addr0 = 14'h0001; addr1 = 14'h0002;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      #2;
      checks++;
      if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL conflict_grant[%0d]: gnt=%b%b want %b%b",
                 i, gnt0, gnt1, (i % 2 == 0), (i % 2 == 1));
      end
      if (i > 0) begin
        checks++;
        if (i % 2 == 1) begin
          if (rv0 !== 1'b1 || rv1 !== 1'b0 || rd0 !== 8'h11) begin
            errors++;
            $display("FAIL conflict_ret0[%0d]: rv=%b%b rd0=%h want 10 11",
                     i, rv0, rv1, rd0);
          end
        end else begin
          if (rv1 !== 1'b1 || rv0 !== 1'b0 || rd1 !== 8'h22) begin
            errors++;
            $display("FAIL conflict_ret1[%0d]: rv=%b%b rd1=%h want 01 22",
                     i, rv0, rv1, rd1);
          end
        end
      end
    end
    tick();
    req0 = 0; req1 = 0;
    #2;
    checks++;
    if (rv1 !== 1'b1 || rv0 !== 1'b0 || rd1 !== 8'h22 || rd0 !== 8'h00) begin
      errors++;
      $display("FAIL conflict_last_ret: rv=%b%b rd1=%h rd0=%h want 01 22 00",
               rv0, rv1, rd1, rd0);
    end
  endtask

  task automatic test_locked_burst();
    do_reset();
    req0 = 1; req1 = 1; we1 = 1; lk1 = 1; addr1 = 14'h0100; wd1 = 8'h3C;
    #2;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL burst_first: gnt=%b%b want 10", gnt0, gnt1);
    end
    for (int b = 0; b < 5; b++) begin
      tick();
      lk1 = (b < 4);
      #2;
      checks++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
        errors++;
        $display("FAIL burst_beat[%0d]: gnt=%b%b want 01", b, gnt0, gnt1);
      end
    end
    tick();
    #2;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL burst_release: gnt=%b%b want 10", gnt0, gnt1);
    end
  endtask

  task automatic test_forced_release();
    do_reset();
    req0b = 1; lk0b = 1; req1b = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      #2;
      checks++;
      if (gnt0b !== 1'b1 || gnt1b !== 1'b0) begin
        errors++;
        $display("FAIL forced_beat[%0d]: gnt=%b%b want 10", i, gnt0b, gnt1b);
      end
    end
    tick();
    #2;
    checks++;
    if (gnt1b !== 1'b1 || gnt0b !== 1'b0) begin
      errors++;
      $display("FAIL forced_switch: gnt=%b%b want 01", gnt0b, gnt1b);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req1 = 1; lk1 = 1; addr1 = 14'h0002; addr0 = 14'h0001;
    #2;
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_grant: gnt=%b%b want 01", gnt0, gnt1);
    end
    tick();
    rst_n = 0;
    req0 = 1;
    #2;
    checks++;
    if ({gnt0, gnt1, rv0, rv1, cs} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_held: gnt=%b%b rv=%b%b cs=%b want all 0",
               gnt0, gnt1, rv0, rv1, cs);
    end
    tick();
    rst_n = 1;
    #2;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: gnt=%b%b want 10", gnt0, gnt1);
    end
    tick();
    req0 = 0; req1 = 0;
    #2;
    checks++;
    if (rv0 !== 1'b1 || rv1 !== 1'b0 || rd0 !== 8'h11) begin
      errors++;
      $display("FAIL midrst_ret: rv=%b%b rd0=%h want 10 11", rv0, rv1, rd0);
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      #2;
      checks++;
      if ({cs, wen, rv0, rv1} !== 4'b0) begin
        errors++;
        $display("FAIL idle[%0d]: cs=%b wen=%b rv=%b%b want 0", i, cs, wen, rv0, rv1);
      end
    end
  endtask

  initial begin
    zaddr = '0;
    zdata = '0;
    srd = '0;
    for (int a = 0; a < 16384; a++) mem[a] = 8'h00;
    mem[1] = 8'h11;
    mem[2] = 8'h22;
    test_reset();
    test_single();
    test_conflict();
    test_locked_burst();
    test_forced_release();
    test_reset_mid_burst();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter that shares the single-port 16K x 8 on-chip SRAM between the CPU port (port 0) and the DMA port (port 1). It accepts one byte access per cycle from a requester using a round-robin policy with optional bounded burst locking. It drives the SRAM strobe, write-enable, address and write data, and returns read data with a valid pulse to the requester that issued the read. It sits between the CPU/DMA memory-side logic and the SRAM wrapper.

## Interface
- ADDR_W, 14, SRAM byte address width
- DATA_W, 8, SRAM data width
- MAX_BURST, 16, maximum granted beats in one locked burst while the other port is waiting; must be at least 1

- HCLK  in  1  single clock for the block and the SRAM
- HRESETn  in  1  reset, asynchronous assert, active-low
- REQ0 / REQ1  in  1  access request, held until GNT
- WE0 / WE1  in  1  1 = write, 0 = read
- LOCK0 / LOCK1  in  1  request to keep ownership after this beat
- ADDR0 / ADDR1  in  ADDR_W  byte address
- WDATA0 / WDATA1  in  DATA_W  write data
- GNT0 / GNT1  out  1  beat accepted this cycle (combinational)
- RDATA0 / RDATA1  out  DATA_W  read data; valid only with RVALIDx
- RVALID0 / RVALID1  out  1  one-cycle read-return pulse (registered)
- SRAMCS  out  1  SRAM clock enable, high for the accepted beat
- SRAMWEN  out  1  SRAM write enable (active-high), equal to the winner's WE
- SRAMADDR  out  ADDR_W  winner's address
- SRAMWDATA  out  DATA_W  winner's write data
- SRAMRDATA  in  DATA_W  SRAM read data, valid one cycle after the strobe

## Operation
- States: ARB, LOCK_P0, LOCK_P1. Other registers: LAST (last granted port), BCNT (beats in the current lock), RD_PEND[1:0] (read-return flags).
- ARB state:
  - Only one port requesting: that port wins.
  - Both ports requesting: the port that is not LAST wins.
  - Reset sets LAST = 1, so port 0 wins the first conflict.
- Grant: GNTx = 1 for the winner only. SRAMCS = 1 and the SRAM buses are muxed from the winner. With no winner, SRAMCS = 0, SRAMWEN = 0, and ADDR/WDATA hold the port-0 values (don't-care).
- Winner x with LOCKx = 1 in ARB: go to LOCK_Px, BCNT = 1, LAST = x.
- LOCK_Px: port x has absolute priority. Each granted beat increments BCNT.
- Exit LOCK_Px to ARB when any of these holds:
  - (a) port x's granted beat has LOCKx = 0. That beat is still granted.
  - (b) REQx = 0 for one cycle. Port y may win in that same cycle through the ARB rules.
  - (c) BCNT == MAX_BURST and REQy = 1. This is a forced release after the beat that reached MAX_BURST. LAST = x, so y wins next.
- BCNT saturates at MAX_BURST when REQy = 0. The lock continues with no forced release.
- Read return: an accepted read sets RD_PEND[x] in the next cycle. RVALIDx = RD_PEND[x] and RDATAx = SRAMRDATA. At most one RD_PEND bit is set in any cycle.
- RDATAx is zero when RVALIDx = 0, so no stale data is exposed.
- A write accepted in cycle N lands in the SRAM at the edge ending cycle N.
- Back-to-back write-then-read to the same address from the same or the other port returns the new data. This is inherent to the SRAM.

## Timing
- Accept cycle N: REQx, GNTx and the SRAM strobe are all in cycle N, with zero added latency. RVALIDx and RDATAx for a read arrive in cycle N+1.
- Throughput: one beat per cycle in aggregate. A single port streaming alone gets 100%.
- Under contention without lock, grants alternate 0,1,0,1.
- GNT and SRAM outputs are combinational from the REQ/WE/LOCK/ADDR/WDATA inputs plus state. Requesters must not make REQ depend combinationally on GNT.
- Reset values while HRESETn = 0:
  - state = ARB, LAST = 1, BCNT = 0, RD_PEND = 0.
  - All GNT, RVALID, RDATA and SRAMCS/SRAMWEN outputs = 0, regardless of REQ.
- Reset asserted mid-burst: the lock is dropped immediately and any pending read return is discarded (no RVALID).
- Reset deassertion: arbitration resumes on the first HCLK edge with HRESETn = 1.
- REQx deasserted without a grant: legal. Nothing is recorded for that request.

## Structure
- Shared package sram_arb_pkg holds:
  - the state enum (ARB, LOCK_P0, LOCK_P1);
  - the port index constants P_CPU = 0 and P_DMA = 1;
  - the default ADDR_W, DATA_W and MAX_BURST values.
- BCNT width: $clog2(MAX_BURST+1).
- No sub-module. The block is a flat arbiter FSM plus mux plus a 2-bit return pipe. The SRAM wrapper is instantiated by the parent alongside it.

## Test plan
- Single port: port 0 writes 0xA5 to 0x0010, then reads it. Required: GNT0 in the same cycle for both beats, RVALID0 = 1 with RDATA0 = 0xA5 one cycle after the read, RVALID1 never asserted.
- Conflict, no lock: both ports hold REQ with reads of 0x0001 and 0x0002 for 4 cycles after reset. Required: grants go 0,1,0,1, and each RVALID carries its own port's data.
- Locked burst: port 1 requests 5 beats with LOCK1 = 1 on the first 4 beats, while port 0 requests continuously. Required: GNT1 for all 5 consecutive cycles, then GNT0 on cycle 6.
- Forced release: MAX_BURST = 4, port 0 holds LOCK0 = 1 indefinitely, port 1 requests. Required: exactly 4 GNT0 beats, then GNT1 on the next cycle.
- Reset mid-burst: assert HRESETn = 0 in the cycle after a locked read grant. Required: RVALID and all GNT outputs are 0, and after release a two-port conflict grants port 0 first.
- Idle: no requests for 10 cycles. Required: SRAMCS = 0, SRAMWEN = 0, and RVALID0 = RVALID1 = 0 throughout.
